fp_operand_sel_pipe: RTL and testbench

Registered, flow-controlled operand-pair selector for the IEEE-754 single-precision adder datapath. Each accepted transaction carries NSRC candidate (A,B) operand pairs from the parallel pre-alignment paths (normal/normal, mixed normal/denormal, zero/special, ...) and a one-hot class code. The block forwards the selected pair to the alignment stage through a valid/ready handshake with a 2-entry skid buffer. Illegal class codes are flagged and counted rather than driven as X.

---
 rtl/fp_operand_sel_pipe.sv | 130 +++++++++++++
 tb/tb_fp_operand_sel_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_sel_pipe.sv
// fp_operand_sel_pipe
//   Picks one of NSRC candidate (A,B) operand pairs for the single-precision
//   adder alignment stage. The pair is chosen by a one-hot class code. The
//   chosen pair goes out through a valid/ready handshake. That handshake is
//   backed by a main output register plus one skid register.
//
//   Illegal class codes have zero bits set or two or more bits set. They
//   produce na=nb=0 with sel_err=1, or they are silently consumed when
//   DROP_ERR=1. In both cases they bump a saturating error counter.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is a flop output)
//   src_a, src_b          NSRC packed candidates, pair i at [i*W +: W]
//   e_data                one-hot class code
//   out_valid / out_ready downstream handshake
//   na, nb, sel_err       selected pair and illegal-code flag
//   err_cnt, clr_cnt      saturating illegal-code count and its sync clear
module fp_operand_sel_pipe #(
  parameter int W        = 37,
  parameter int NSRC     = 4,
  parameter int CNTW     = 8,
  parameter int DROP_ERR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSRC*W-1:0] src_a,
  input  logic [NSRC*W-1:0] src_b,
  input  logic [NSRC-1:0]   e_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      na,
  output logic [W-1:0]      nb,
  output logic              sel_err,
  output logic [CNTW-1:0]   err_cnt,
  input  logic              clr_cnt
);

  function automatic logic [CNTW-1:0] satInc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  logic [W-1:0]    selA, selB;
  logic            codeLegal;
  logic            accept, fwd, mainFree;

  logic [W-1:0]    skidA_p0, skidB_p0;
  logic            skidErr_p0, vld_p0;
  logic [W-1:0]    mainA_p1, mainB_p1;
  logic            mainErr_p1, vld_p1;
  logic [CNTW-1:0] errCnt;

  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (e_data[i]) begin
        selA |= src_a[i*W +: W];
        selB |= src_b[i*W +: W];
      end
    end
    // Clearing the lowest set bit leaves zero only for a single-bit code.
    codeLegal = (e_data != '0) && ((e_data & (e_data - NSRC'(1))) == '0);
    if (!codeLegal) begin
      selA = '0;
      selB = '0;
    end
  end

  assign in_ready = !vld_p0;
  assign accept   = in_valid && in_ready;
  assign fwd      = accept && (codeLegal || (DROP_ERR == 0));
  assign mainFree = !vld_p1 || out_ready;

  // ---- stage p0: skid register (holds the data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (!mainFree && fwd) begin
      skidA_p0   <= selA;
      skidB_p0   <= selB;
      skidErr_p0 <= !codeLegal;
    end
  end

  // ---- stage p1: main output register, valids and error counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      mainA_p1   <= '0;
      mainB_p1   <= '0;
      mainErr_p1 <= 1'b0;
      errCnt     <= '0;
    end else begin
      if (mainFree) begin
        // A full skid always refills main first. A new accept cannot collide
        // with it because in_ready is low whenever the skid is full.
        if (vld_p0) begin
          vld_p1     <= 1'b1;
          mainA_p1   <= skidA_p0;
          mainB_p1   <= skidB_p0;
          mainErr_p1 <= skidErr_p0;
          vld_p0     <= 1'b0;
        end else if (fwd) begin
          vld_p1     <= 1'b1;
          mainA_p1   <= selA;
          mainB_p1   <= selB;
          mainErr_p1 <= !codeLegal;
        end else begin
          vld_p1     <= 1'b0;
        end
      end else if (fwd) begin
        vld_p0 <= 1'b1;
      end

      if (clr_cnt)
        errCnt <= '0;
      else if (accept && !codeLegal)
        errCnt <= satInc(errCnt);
    end
  end

  assign out_valid = vld_p1;
  assign na        = mainA_p1;
  assign nb        = mainB_p1;
  assign sel_err   = mainErr_p1;
  assign err_cnt   = errCnt;

endmodule

// File: tb/tb_fp_operand_sel_pipe.sv
module tb_fp_operand_sel_pipe;
  localparam int W = 37, NSRC = 4, CNTW = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, dValid = 1'b0;
  logic              out_ready = 1'b1, clr_cnt = 1'b0;
  logic [NSRC*W-1:0] src_a = '0, src_b = '0;
  logic [NSRC-1:0]   e_data = '0;

  logic              in_ready, out_valid, sel_err;
  logic [W-1:0]      na, nb;
  logic [CNTW-1:0]   err_cnt;
  logic              dInReady, dOutValid, dSelErr;
  logic [W-1:0]      dNa, dNb;
  logic [CNTW-1:0]   dErrCnt;

  int checks = 0, errors = 0;
  item_t q[$], dq[$];
  int cnt = 0, dCnt = 0;

  always #5 clk = ~clk;

  fp_operand_sel_pipe #(.W(W), .NSRC(NSRC), .CNTW(CNTW), .DROP_ERR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .e_data(e_data), .out_valid(out_valid),
    .out_ready(out_ready), .na(na), .nb(nb), .sel_err(sel_err),
    .err_cnt(err_cnt), .clr_cnt(clr_cnt));

  fp_operand_sel_pipe #(.W(W), .NSRC(NSRC), .CNTW(CNTW), .DROP_ERR(1)) dutDrop (
    .clk(clk), .rst_n(rst_n), .in_valid(dValid), .in_ready(dInReady),
    .src_a(src_a), .src_b(src_b), .e_data(e_data), .out_valid(dOutValid),
    .out_ready(out_ready), .na(dNa), .nb(dNb), .sel_err(dSelErr),
    .err_cnt(dErrCnt), .clr_cnt(clr_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference selection: exactly one bit set picks that pair, anything else is an error.
  function automatic item_t refSel(input logic [NSRC*W-1:0] a, input logic [NSRC*W-1:0] b,
                                   input logic [NSRC-1:0] e);
    item_t it;
    it.a = '0; it.b = '0; it.err = 1'b1;
    if ($countones(e) == 1) begin
      it.err = 1'b0;
      for (int i = 0; i < NSRC; i++)
        if (e[i]) begin
          it.a = a[i*W +: W];
          it.b = b[i*W +: W];
        end
    end
    return it;
  endfunction

  function automatic logic [W-1:0] rndOp();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic rndSrc();
    for (int i = 0; i < NSRC; i++) begin
      src_a[i*W +: W] = rndOp();
      src_b[i*W +: W] = rndOp();
    end
  endtask

  // One clock: the model is a 2-deep FIFO. Acceptance and drain are decided
  // from the inputs present at the edge. Outputs are compared 1 time unit later.
  task automatic cycle();
    bit acc, drn, dAcc, dDrn;
    item_t it;
    acc  = in_valid && (q.size() < 2);
    drn  = (q.size() > 0) && out_ready;
    dAcc = dValid && (dq.size() < 2);
    dDrn = (dq.size() > 0) && out_ready;
    it   = refSel(src_a, src_b, e_data);
    chk("in_ready", in_ready, q.size() < 2);
    chk("drop_in_ready", dInReady, dq.size() < 2);
    @(posedge clk);
    #1;
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(it);
    if (dDrn) void'(dq.pop_front());
    if (dAcc && !it.err) dq.push_back(it);
    if (clr_cnt) begin
      cnt = 0; dCnt = 0;
    end else begin
      if (acc && it.err) cnt = (cnt < 255) ? cnt + 1 : 255;
      if (dAcc && it.err) dCnt = (dCnt < 255) ? dCnt + 1 : 255;
    end
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("na", na, q[0].a);
      chk("nb", nb, q[0].b);
      chk("sel_err", sel_err, q[0].err);
    end
    chk("err_cnt", err_cnt, cnt);
    chk("drop_out_valid", dOutValid, dq.size() > 0);
    if (dq.size() > 0) begin
      chk("drop_na", dNa, dq[0].a);
      chk("drop_nb", dNb, dq[0].b);
      chk("drop_sel_err", dSelErr, 1'b0);
    end
    chk("drop_err_cnt", dErrCnt, dCnt);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_na", na, '0);
    chk("rst_nb", nb, '0);
    chk("rst_sel_err", sel_err, 1'b0);
    chk("rst_err_cnt", err_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single legal transaction on pair 1
    rndSrc();
    src_a[1*W +: W] = 37'h0_0040_0000;
    src_b[1*W +: W] = 37'h1_2345_6780;
    e_data = 4'b0010; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("single_na", na, 37'h0_0040_0000);
    chk("single_nb", nb, 37'h1_2345_6780);
    chk("single_sel_err", sel_err, 1'b0);
    cycle();

    // 16 back-to-back legal transactions
    for (int k = 0; k < 16; k++) begin
      rndSrc();
      e_data = NSRC'(1) << (k % 4);
      in_valid = 1'b1;
      cycle();
      chk("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    cycle();

    // Backpressure: three offered with out_ready low
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rndSrc();
      e_data = NSRC'(1) << k;
      in_valid = 1'b1;
      cycle();
    end
    chk("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      in_valid = 1'b0;
    end

    // Illegal codes on both variants
    e_data = 4'b0000; in_valid = 1'b1; rndSrc(); cycle();
    e_data = 4'b0110; rndSrc(); cycle();
    in_valid = 1'b0; cycle();
    chk("illegal_err_cnt", err_cnt, 8'd2);
    e_data = 4'b0000; dValid = 1'b1; rndSrc(); cycle();
    e_data = 4'b0110; rndSrc(); cycle();
    e_data = 4'b0100; rndSrc(); cycle();
    dValid = 1'b0; cycle();
    chk("drop_err_cnt2", dErrCnt, 8'd2);

    // Saturation, then clear beating a same-cycle increment
    e_data = 4'b1011; in_valid = 1'b1;
    for (int k = 0; k < 300; k++) cycle();
    chk("sat_err_cnt", err_cnt, 8'hFF);
    clr_cnt = 1'b1; e_data = 4'b0000;
    cycle();
    clr_cnt = 1'b0; in_valid = 1'b0;
    chk("clr_err_cnt", err_cnt, 8'h00);
    cycle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rndSrc();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) != 0) e_data = NSRC'(1) << $urandom_range(0, NSRC-1);
      else e_data = NSRC'($urandom_range(0, 15));
      cycle();
    end
    clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    // Async reset with main and skid full
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rndSrc(); e_data = NSRC'(1) << k; cycle();
    end
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_na", na, '0);
    chk("arst_nb", nb, '0);
    chk("arst_sel_err", sel_err, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    q.delete(); dq.delete(); cnt = 0; dCnt = 0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    cycle(); cycle();
    rndSrc(); e_data = 4'b1000; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_na", na, src_a[3*W +: W]);
    cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
